// File: rtl/prga.sv
// RC4 pseudo-random generation stage: continues permuting S, generates one pad byte per
// ciphertext byte and writes the length-prefixed plaintext.
module prga (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] ct_addr,
   input  logic [7:0] ct_rddata,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic [7:0] pt_wrdata,
   output logic       pt_wren
);

   typedef enum logic [3:0] {
      IDLE,
      RD_LEN,
      WR_LEN,
      RD_SI,
      LT_SI,
      RD_SJ,
      LT_SJ,
      WR_SI,
      WR_SJ,
      RD_PAD,
      WR_PT,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] i_q, i_d;
   logic [7:0] j_q, j_d;
   logic [8:0] k_q, k_d;
   logic [7:0] len_q, len_d;
   logic [7:0] si_q, si_d;
   logic [7:0] sj_q, sj_d;
   logic [7:0] ct_q, ct_d;

   logic       unused_pt_rd;
   assign unused_pt_rd = ^pt_rddata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         k_q     <= 9'd0;
         len_q   <= 8'd0;
         si_q    <= 8'd0;
         sj_q    <= 8'd0;
         ct_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         ct_q    <= ct_d;
      end
   end

   // Every read takes two states: address out, then data valid the following cycle.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      len_d     = len_q;
      si_d      = si_q;
      sj_d      = sj_q;
      ct_d      = ct_q;
      rdy       = 1'b0;
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      ct_addr   = 8'd0;
      pt_addr   = 8'd0;
      pt_wrdata = 8'd0;
      pt_wren   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            rdy = 1'b1;
            if (en) begin
               state_d = RD_LEN;
               i_d     = 8'd0;
               j_d     = 8'd0;
               k_d     = 9'd1;
            end else begin
               state_d = IDLE;
            end
         end
         RD_LEN: begin
            ct_addr = 8'd0;
            state_d = WR_LEN;
         end
         WR_LEN: begin
            len_d     = ct_rddata;
            pt_addr   = 8'd0;
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
            state_d   = (ct_rddata == 8'd0) ? DONE : RD_SI;
         end
         RD_SI: begin
            s_addr  = i_q + 8'd1;
            state_d = LT_SI;
         end
         LT_SI: begin
            si_d    = s_rddata;
            i_d     = i_q + 8'd1;
            j_d     = j_q + s_rddata;
            state_d = RD_SJ;
         end
         RD_SJ: begin
            s_addr  = j_q;
            ct_addr = k_q[7:0];
            state_d = LT_SJ;
         end
         LT_SJ: begin
            sj_d    = s_rddata;
            ct_d    = ct_rddata;
            state_d = WR_SI;
         end
         WR_SI: begin
            s_addr   = i_q;
            s_wrdata = sj_q;
            s_wren   = 1'b1;
            state_d  = WR_SJ;
         end
         WR_SJ: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
            state_d  = RD_PAD;
         end
         // The pad is read from RAM after both swap writes, so i==j needs no special case.
         RD_PAD: begin
            s_addr  = si_q + sj_q;
            state_d = WR_PT;
         end
         WR_PT: begin
            pt_addr   = k_q[7:0];
            pt_wrdata = ct_q ^ s_rddata;
            pt_wren   = 1'b1;
            if (k_q == {1'b0, len_q}) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + 9'd1;
               state_d = RD_SI;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: RAM models, an RC4 reference model feeding a write
// scoreboard, a table of known-answer messages and hand-written multi-cycle sequences.
module tb_prga;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rdy;
   logic [7:0] s_addr, s_rddata, s_wrdata;
   logic       s_wren;
   logic [7:0] ct_addr, ct_rddata;
   logic [7:0] pt_addr, pt_rddata, pt_wrdata;
   logic       pt_wren;

   prga dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren),
      .ct_addr   (ct_addr),
      .ct_rddata (ct_rddata),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .pt_wrdata (pt_wrdata),
      .pt_wren   (pt_wren)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  s_mem  [256];
   logic [7:0]  ct_mem [256];
   logic [7:0]  pt_mem [256];
   logic [7:0]  ref_s  [256];
   logic [7:0]  exp_pt [256];
   logic [15:0] exp_q  [$];

   int n_checks = 0;
   int n_fail   = 0;
   int s_wr_count, pt_wr_count, len_wr_count;

   // Synchronous RAMs: address registered at the edge, data valid the next cycle.
   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[ct_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (s_wren)  s_mem[s_addr]   = s_wrdata;
      if (pt_wren) pt_mem[pt_addr] = pt_wrdata;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Every plaintext write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_wren) s_wr_count++;
         if (pt_wren) begin
            pt_wr_count++;
            if (pt_addr == 8'd0) len_wr_count++;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected pt write", {16'd0, pt_addr, pt_wrdata}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("pt write addr/data", {16'd0, pt_addr, pt_wrdata},
                           {16'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic loadIdentity();
      for (int x = 0; x < 256; x++) begin
         s_mem[x] = x[7:0];
         ref_s[x] = x[7:0];
      end
   endtask

   task automatic loadKsa();
      logic [7:0] key [3];
      logic [7:0] j, t;
      key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
      for (int x = 0; x < 256; x++) ref_s[x] = x[7:0];
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + ref_s[x] + key[x % 3];
         t = ref_s[x];
         ref_s[x] = ref_s[j];
         ref_s[j] = t;
      end
      for (int x = 0; x < 256; x++) s_mem[x] = ref_s[x];
   endtask

   // RC4 PRGA reference over ref_s; pushes the expected pt writes in order.
   task automatic modelMessage();
      logic [7:0] len, i, j, si, sj, pad, idx, b;
      len = ct_mem[0];
      exp_q.push_back({8'h00, len});
      exp_pt[0] = len;
      i = 8'd0;
      j = 8'd0;
      for (int k = 1; k <= int'(len); k++) begin
         i = i + 8'd1;
         si = ref_s[i];
         j = j + si;
         sj = ref_s[j];
         ref_s[i] = sj;
         ref_s[j] = si;
         idx = si + sj;
         pad = ref_s[idx];
         b = ct_mem[k[7:0]] ^ pad;
         exp_pt[k[7:0]] = b;
         exp_q.push_back({k[7:0], b});
      end
   endtask

   task automatic clearCounts();
      s_wr_count   = 0;
      pt_wr_count  = 0;
      len_wr_count = 0;
      for (int x = 0; x < 256; x++) pt_mem[x] = 8'hEE;
   endtask

   task automatic applyStimulus(input bit hold);
      @(negedge clk);
      checkOutput("rdy before start", rdy, 1);
      en = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) en = 1'b0;
   endtask

   task automatic waitDone(input string name, input int bound, input bit noise);
      int cycles;
      bit done;
      cycles = 0;
      done   = 1'b0;
      while (!done && cycles < bound) begin
         @(negedge clk);
         cycles++;
         if (rdy) done = 1'b1;
         else if (noise) en = ((cycles % 37) == 5);
      end
      if (noise) en = 1'b0;
      checkOutput({name, " rdy within bound"}, done, 1);
   endtask

   function automatic int sMismatches();
      int n = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) n++;
      return n;
   endfunction

   typedef struct {
      string           name;
      bit              use_ksa;
      logic [0:9][7:0] ct;
      logic [0:9][7:0] pt;
      int              bound;
   } vec_t;

   vec_t tbl [3];

   initial begin
      tbl[0].name = "identity";  tbl[0].use_ksa = 1'b0; tbl[0].bound = 48;
      tbl[0].ct = {8'h03, 8'h41, 8'h42, 8'h43, 48'h0};
      tbl[0].pt = {8'h03, 8'h43, 8'h47, 8'h44, 48'h0};
      tbl[1].name = "ksa_key";   tbl[1].use_ksa = 1'b1; tbl[1].bound = 132;
      tbl[1].ct = {8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      tbl[1].pt = {8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      tbl[2].name = "zero_len";  tbl[2].use_ksa = 1'b0; tbl[2].bound = 6;
      tbl[2].ct = {8'h00, 72'h0};
      tbl[2].pt = {8'h00, 72'h0};

      rst_n = 1'b0;
      en    = 1'b0;
      loadIdentity();
      for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
      clearCounts();

      #12;
      checkOutput("reset rdy", rdy, 1);
      checkOutput("reset s_wren", s_wren, 0);
      checkOutput("reset pt_wren", pt_wren, 0);
      checkOutput("reset s_addr", s_addr, 0);
      checkOutput("reset ct_addr", ct_addr, 0);
      checkOutput("reset pt_addr", pt_addr, 0);
      checkOutput("reset s_wrdata", s_wrdata, 0);
      checkOutput("reset pt_wrdata", pt_wrdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle no s writes", s_wr_count, 0);
      checkOutput("idle no pt writes", pt_wr_count, 0);

      for (int r = 0; r < 3; r++) begin
         int len;
         if (tbl[r].use_ksa) loadKsa();
         else loadIdentity();
         for (int x = 0; x < 256; x++) ct_mem[x] = (x < 10) ? tbl[r].ct[x] : 8'h00;
         len = int'(tbl[r].ct[0]);
         clearCounts();
         modelMessage();
         applyStimulus(1'b0);
         waitDone(tbl[r].name, tbl[r].bound, 1'b0);
         checkOutput({tbl[r].name, " scoreboard drained"}, exp_q.size(), 0);
         checkOutput({tbl[r].name, " pt write count"}, pt_wr_count, len + 1);
         checkOutput({tbl[r].name, " s write count"}, s_wr_count, 2 * len);
         for (int k = 0; k <= len; k++)
            checkOutput({tbl[r].name, " pt byte"}, pt_mem[k], tbl[r].pt[k]);
         checkOutput({tbl[r].name, " pt above L untouched"}, pt_mem[len + 1], 8'hEE);
         checkOutput({tbl[r].name, " S vs model"}, sMismatches(), 0);
         if (r == 0) begin
            int others = 0;
            checkOutput("identity S[1]", s_mem[1], 8'h01);
            checkOutput("identity S[2]", s_mem[2], 8'h03);
            checkOutput("identity S[3]", s_mem[3], 8'h05);
            checkOutput("identity S[5]", s_mem[5], 8'h02);
            for (int x = 0; x < 256; x++)
               if (x != 2 && x != 3 && x != 5 && s_mem[x] != x[7:0]) others++;
            checkOutput("identity other S unchanged", others, 0);
         end
         exp_q.delete();
      end

      // Full-length message with en noise while busy.
      loadIdentity();
      ct_mem[0] = 8'hFF;
      for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(0, 255));
      clearCounts();
      modelMessage();
      applyStimulus(1'b0);
      waitDone("len255", 14 * 255 + 6, 1'b1);
      checkOutput("len255 scoreboard drained", exp_q.size(), 0);
      checkOutput("len255 run count", len_wr_count, 1);
      checkOutput("len255 pt write count", pt_wr_count, 256);
      checkOutput("len255 s write count", s_wr_count, 510);
      checkOutput("len255 S vs model", sMismatches(), 0);
      repeat (3) @(negedge clk);
      checkOutput("len255 no restart", len_wr_count, 1);
      exp_q.delete();

      // Back-to-back: en held high so the second message is taken as rdy rises.
      loadIdentity();
      for (int x = 0; x < 256; x++) ct_mem[x] = (x < 10) ? tbl[0].ct[x] : 8'h00;
      clearCounts();
      modelMessage();
      modelMessage();
      applyStimulus(1'b1);
      waitDone("b2b first", 48, 1'b0);
      @(posedge clk);
      #1;
      en = 1'b0;
      waitDone("b2b second", 48, 1'b0);
      checkOutput("b2b scoreboard drained", exp_q.size(), 0);
      checkOutput("b2b run count", len_wr_count, 2);
      for (int k = 1; k <= 3; k++) checkOutput("b2b final pt", pt_mem[k], exp_pt[k]);
      checkOutput("b2b S vs model", sMismatches(), 0);
      exp_q.delete();

      // Reset in the middle of a message.
      loadIdentity();
      ct_mem[0] = 8'hFF;
      clearCounts();
      modelMessage();
      applyStimulus(1'b0);
      repeat (30) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset s_wren", s_wren, 0);
      checkOutput("midreset pt_wren", pt_wren, 0);
      checkOutput("midreset rdy", rdy, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      clearCounts();
      repeat (20) @(negedge clk);
      checkOutput("after reset rdy", rdy, 1);
      checkOutput("after reset no s writes", s_wr_count, 0);
      checkOutput("after reset no pt writes", pt_wr_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
